cosim_commit_serializer: RTL
============================

# cosim_commit_serializer

Synthesizable front end for the Dromajo co-simulation path. It collects per-cycle retirement bundles from up to NUM_HARTS cores, each up to COMMIT_WIDTH instructions wide plus an interrupt/exception event. It buffers them per hart in program order and emits one record per handshake on a single valid/ready stream. That stream feeds the DPI step/trap bridge, or a host link in FPGA builds, so the cosim consumer can be slower than the cores and can serve many harts.

## Interface
Parameters:
- NUM_HARTS, 2, number of hart input channels
- COMMIT_WIDTH, 2, retire lanes per hart per cycle
- DEPTH, 16, per-hart FIFO entries; must be ≥ COMMIT_WIDTH+1
- XLEN, 64, PC/wdata/mstatus/cause width
- INST_BITS, 32, instruction width
- RD, 5, destination register index width
- HARTID_LEN, max(1, clog2(NUM_HARTS)), output hart id width

Ports. Input buses are flat, and hart h lane l occupies slice index h*COMMIT_WIDTH+l:
- clock  in  1  sole clock
- reset  in  1  synchronous, active-high
- in_valid  in  NUM_HARTS*COMMIT_WIDTH  lane retires an instruction
- in_pc, in_wdata, in_mstatus  in  XLEN*NUM_HARTS*COMMIT_WIDTH each  per-lane values
- in_inst  in  INST_BITS*NUM_HARTS*COMMIT_WIDTH
- in_wdata_dest  in  RD*NUM_HARTS*COMMIT_WIDTH
- in_check, in_wdata_valid, in_writes_back  in  NUM_HARTS*COMMIT_WIDTH each
- in_int_xcpt  in  NUM_HARTS  trap event this cycle
- in_cause  in  XLEN*NUM_HARTS
- out_valid  out  1 / out_ready  in  1  output handshake
- out_hartid  out  HARTID_LEN
- out_is_trap  out  1  record is a trap (only out_cause meaningful)
- out_pc, out_wdata, out_mstatus, out_cause  out  XLEN each
- out_inst  out  INST_BITS / out_wdata_dest  out  RD
- out_check, out_wdata_valid, out_writes_back  out  1 each
- overflow  out  NUM_HARTS  sticky per-hart drop flag
- idle  out  1  all FIFOs empty

## Operation
Each hart has a circular FIFO of DEPTH records: wr_ptr, rd_ptr, and a count of width clog2(DEPTH+1). Pointers wrap modulo DEPTH; non-power-of-2 DEPTH is legal.

**Enqueue**, per hart per cycle:
- n = popcount(valid lanes) + in_int_xcpt[h].
- Valid lanes are compacted in ascending lane order, skipping invalid lanes. The trap record is written after all instruction records of the same cycle.
- Free space is DEPTH − count, using count before this cycle's dequeue. A same-cycle pop is not credited.
- If n ≤ free, all n records are written and count += n (− 1 if popped).
- If n > free, the whole bundle is dropped. overflow[h] is set and held until reset. Already-queued records drain normally.

**Arbitration:**
- A round-robin pointer rr selects the first non-empty hart at or after rr.
- On a handshake (out_valid && out_ready), that hart pops one record and rr becomes the served hart + 1 (mod NUM_HARTS).
- While out_valid && !out_ready, the selection is locked. All out_* fields must stay stable until accepted, even if another hart becomes non-empty.
- Records of one hart always leave in enqueue order. There is no ordering guarantee between harts.

**Output fields:**
- out_* comes from the selected FIFO head.
- For trap records, out_is_trap=1 and out_cause holds the cause. All other data fields are driven 0.
- For instruction records, out_is_trap=0 and out_cause is driven 0.

**Status:**
- idle = 1 iff every count is 0.

## Timing
- Reset values: out_valid=0, all out_* data=0, overflow=0, idle=1, rr=0, all pointers and counts 0. Reset asserted mid-stream empties all FIFOs in the same edge, and records in flight are lost.
- Latency: a record enqueued at edge k can appear on out_* after edge k (combinational read of the FIFO head). Minimum input-to-output latency is 1 cycle.
- Throughput: 1 record/cycle total across all harts, independent of the dequeue and enqueue mix.
- Full FIFO with a simultaneous push and pop: the push is dropped if n > 0, because free = 0.
- out_ready is ignored while out_valid=0.

## Test plan
- Single hart, lanes {0,1} valid with pc 0x80000000 and 0x80000004, out_ready=1 → two records in pc order on consecutive cycles, first at 1 cycle latency, out_hartid=0.
- Lane 0 invalid, lane 1 valid, plus int_xcpt with cause 0x8000000000000007 in the same cycle → instruction record, then trap record with out_is_trap=1 and the cause; no gap record.
- Two harts each pushing 1 record/cycle, out_ready=1 → output alternates hartid 0,1,0,1. With ready held low for 5 cycles, out_* stays bit-stable.
- DEPTH=4: fill hart 0 to count=3, then push a 2-lane bundle → bundle dropped, overflow[0]=1 sticky, the 3 old records drain intact.
- Fill to count=DEPTH with pop plus 1-record push in the same cycle → push dropped, overflow set. Wrap test: 3×DEPTH records in and out keep order.
- Assert reset for 1 cycle while 6 records are queued → next cycle out_valid=0, idle=1, overflow=0. New pushes are delivered normally.

Source files
------------

// File: rtl/cosim_commit_serializer.sv
// ---------------------------------------------------------------------------
// cosim_commit_serializer
//
// Purpose: gathers per-cycle retirement bundles (up to COMMIT_WIDTH retired
// instructions plus one interrupt/exception event) from NUM_HARTS cores. It
// keeps them per hart, in program order, in a circular FIFO. It then
// serializes them onto one valid/ready record stream for the co-simulation
// consumer, which may be slower than the cores.
//
// Ports:
//   clock, reset            sole clock, synchronous active-high reset
//   in_valid .. in_writes_back
//                           flat per-lane retirement fields; hart h lane l
//                           uses slice index h*COMMIT_WIDTH+l
//   in_int_xcpt, in_cause   per-hart trap event and its cause
//   out_valid / out_ready   output record handshake
//   out_hartid              hart that produced the current record
//   out_is_trap             record is a trap (only out_cause is meaningful)
//   out_pc .. out_writes_back
//                           record payload (zero when out_valid is low)
//   overflow                sticky per-hart "a bundle was dropped" flag
//   idle                    every hart FIFO is empty
// ---------------------------------------------------------------------------
module cosim_commit_serializer #(
   parameter int NUM_HARTS    = 2,
   parameter int COMMIT_WIDTH = 2,
   parameter int DEPTH        = 16,
   parameter int XLEN         = 64,
   parameter int INST_BITS    = 32,
   parameter int RD           = 5,
   parameter int HARTID_LEN   = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1
) (
   input  logic                                   clock,
   input  logic                                   reset,
   input  logic [NUM_HARTS*COMMIT_WIDTH-1:0]      in_valid,
   input  logic [XLEN*NUM_HARTS*COMMIT_WIDTH-1:0] in_pc,
   input  logic [XLEN*NUM_HARTS*COMMIT_WIDTH-1:0] in_wdata,
   input  logic [XLEN*NUM_HARTS*COMMIT_WIDTH-1:0] in_mstatus,
   input  logic [INST_BITS*NUM_HARTS*COMMIT_WIDTH-1:0] in_inst,
   input  logic [RD*NUM_HARTS*COMMIT_WIDTH-1:0]   in_wdata_dest,
   input  logic [NUM_HARTS*COMMIT_WIDTH-1:0]      in_check,
   input  logic [NUM_HARTS*COMMIT_WIDTH-1:0]      in_wdata_valid,
   input  logic [NUM_HARTS*COMMIT_WIDTH-1:0]      in_writes_back,
   input  logic [NUM_HARTS-1:0]                   in_int_xcpt,
   input  logic [XLEN*NUM_HARTS-1:0]              in_cause,
   output logic                                   out_valid,
   input  logic                                   out_ready,
   output logic [HARTID_LEN-1:0]                  out_hartid,
   output logic                                   out_is_trap,
   output logic [XLEN-1:0]                        out_pc,
   output logic [XLEN-1:0]                        out_wdata,
   output logic [XLEN-1:0]                        out_mstatus,
   output logic [XLEN-1:0]                        out_cause,
   output logic [INST_BITS-1:0]                   out_inst,
   output logic [RD-1:0]                          out_wdata_dest,
   output logic                                   out_check,
   output logic                                   out_wdata_valid,
   output logic                                   out_writes_back,
   output logic [NUM_HARTS-1:0]                   overflow,
   output logic                                   idle
);

   localparam int SLOTS = COMMIT_WIDTH + 1;
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int N_W   = $clog2(SLOTS + 1);

   typedef struct packed {
      logic                 is_trap;
      logic [XLEN-1:0]      pc;
      logic [XLEN-1:0]      wdata;
      logic [XLEN-1:0]      mstatus;
      logic [XLEN-1:0]      cause;
      logic [INST_BITS-1:0] inst;
      logic [RD-1:0]        wdata_dest;
      logic                 check;
      logic                 wdata_valid;
      logic                 writes_back;
   } rec_t;

   rec_t                  mem    [NUM_HARTS][DEPTH];
   logic [PTR_W-1:0]      wr_ptr [NUM_HARTS];
   logic [PTR_W-1:0]      rd_ptr [NUM_HARTS];
   logic [CNT_W-1:0]      count  [NUM_HARTS];
   logic [HARTID_LEN-1:0] rr;
   logic [HARTID_LEN-1:0] lock_hart;
   logic                  locked;

   rec_t                  slot   [NUM_HARTS][SLOTS];
   logic [N_W-1:0]        slot_n [NUM_HARTS];
   logic [PTR_W-1:0]      wr_idx [NUM_HARTS][SLOTS];
   logic [NUM_HARTS-1:0]  nonempty;
   logic [NUM_HARTS-1:0]  accept;
   logic [NUM_HARTS-1:0]  drop;
   logic [NUM_HARTS-1:0]  pop;
   logic [HARTID_LEN-1:0] sel_hart;
   logic [HARTID_LEN-1:0] hi_hart;
   logic [HARTID_LEN-1:0] lo_hart;
   logic                  found_hi;
   logic                  handshake;
   rec_t                  head;

   // Circular pointer advance. DEPTH need not be a power of two, and the
   // increment never exceeds DEPTH, so one conditional subtract is enough.
   function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input int inc);
      int sum;
      sum = int'(p) + inc;
      if (sum >= DEPTH) sum = sum - DEPTH;
      return PTR_W'(sum);
   endfunction

   // Compact each hart's bundle into consecutive slots: valid lanes in
   // ascending order first, then the trap record last. Unused payload fields
   // are zero, so trap records carry only the cause and instruction records
   // carry a zero cause.
   always_comb begin : compact_blk
      int fill;
      for (int h = 0; h < NUM_HARTS; h++) begin
         fill = 0;
         for (int s = 0; s < SLOTS; s++) begin
            slot[h][s] = '0;
         end
         for (int l = 0; l < COMMIT_WIDTH; l++) begin
            if (in_valid[h*COMMIT_WIDTH+l]) begin
               slot[h][fill].pc          = in_pc[(h*COMMIT_WIDTH+l)*XLEN +: XLEN];
               slot[h][fill].wdata       = in_wdata[(h*COMMIT_WIDTH+l)*XLEN +: XLEN];
               slot[h][fill].mstatus     = in_mstatus[(h*COMMIT_WIDTH+l)*XLEN +: XLEN];
               slot[h][fill].inst        = in_inst[(h*COMMIT_WIDTH+l)*INST_BITS +: INST_BITS];
               slot[h][fill].wdata_dest  = in_wdata_dest[(h*COMMIT_WIDTH+l)*RD +: RD];
               slot[h][fill].check       = in_check[h*COMMIT_WIDTH+l];
               slot[h][fill].wdata_valid = in_wdata_valid[h*COMMIT_WIDTH+l];
               slot[h][fill].writes_back = in_writes_back[h*COMMIT_WIDTH+l];
               fill = fill + 1;
            end
         end
         if (in_int_xcpt[h]) begin
            slot[h][fill].is_trap = 1'b1;
            slot[h][fill].cause   = in_cause[h*XLEN +: XLEN];
            fill = fill + 1;
         end
         slot_n[h] = N_W'(fill);
      end
   end

   // A bundle goes in all-or-nothing. Free space uses the pre-pop count, so
   // a full FIFO never accepts even when it is being drained this same cycle.
   always_comb begin
      for (int h = 0; h < NUM_HARTS; h++) begin
         nonempty[h] = (count[h] != '0);
         accept[h]   = (slot_n[h] != '0) && (int'(slot_n[h]) <= (DEPTH - int'(count[h])));
         drop[h]     = (int'(slot_n[h]) > (DEPTH - int'(count[h])));
         for (int s = 0; s < SLOTS; s++) begin
            wr_idx[h][s] = ptr_add(wr_ptr[h], s);
         end
      end
   end

   // Round-robin pick: lowest non-empty hart at or above rr, else the lowest
   // non-empty hart below rr. A stalled record keeps its hart locked so the
   // presented record cannot change under the consumer.
   always_comb begin
      found_hi = 1'b0;
      hi_hart  = '0;
      lo_hart  = '0;
      for (int h = NUM_HARTS - 1; h >= 0; h--) begin
         if (nonempty[h]) begin
            if (h >= int'(rr)) begin
               found_hi = 1'b1;
               hi_hart  = HARTID_LEN'(h);
            end else begin
               lo_hart  = HARTID_LEN'(h);
            end
         end
      end
      if (locked) begin
         sel_hart = lock_hart;
      end else if (found_hi) begin
         sel_hart = hi_hart;
      end else begin
         sel_hart = lo_hart;
      end
   end

   assign out_valid = |nonempty;
   assign idle      = ~|nonempty;
   assign handshake = out_valid && out_ready;

   always_comb begin
      for (int h = 0; h < NUM_HARTS; h++) begin
         pop[h] = handshake && (sel_hart == HARTID_LEN'(h));
      end
   end

   // Present the selected FIFO head; everything reads zero with no record.
   always_comb begin
      head            = mem[sel_hart][rd_ptr[sel_hart]];
      out_hartid      = '0;
      out_is_trap     = 1'b0;
      out_pc          = '0;
      out_wdata       = '0;
      out_mstatus     = '0;
      out_cause       = '0;
      out_inst        = '0;
      out_wdata_dest  = '0;
      out_check       = 1'b0;
      out_wdata_valid = 1'b0;
      out_writes_back = 1'b0;
      if (out_valid) begin
         out_hartid      = sel_hart;
         out_is_trap     = head.is_trap;
         out_pc          = head.pc;
         out_wdata       = head.wdata;
         out_mstatus     = head.mstatus;
         out_cause       = head.cause;
         out_inst        = head.inst;
         out_wdata_dest  = head.wdata_dest;
         out_check       = head.check;
         out_wdata_valid = head.wdata_valid;
         out_writes_back = head.writes_back;
      end
   end

   // Record storage needs no reset; validity is tracked by the counts.
   always_ff @(posedge clock) begin
      for (int h = 0; h < NUM_HARTS; h++) begin
         for (int s = 0; s < SLOTS; s++) begin
            if (accept[h] && (s < int'(slot_n[h]))) begin
               mem[h][wr_idx[h][s]] <= slot[h][s];
            end
         end
      end
   end

   // Pointer, count, arbitration and sticky overflow state.
   always_ff @(posedge clock) begin
      if (reset) begin
         rr        <= '0;
         lock_hart <= '0;
         locked    <= 1'b0;
         overflow  <= '0;
         for (int h = 0; h < NUM_HARTS; h++) begin
            wr_ptr[h] <= '0;
            rd_ptr[h] <= '0;
            count[h]  <= '0;
         end
      end else begin
         locked    <= out_valid && !out_ready;
         lock_hart <= sel_hart;
         if (handshake) begin
            rr <= (int'(sel_hart) == NUM_HARTS - 1) ? '0 : sel_hart + HARTID_LEN'(1);
         end
         for (int h = 0; h < NUM_HARTS; h++) begin
            if (drop[h]) begin
               overflow[h] <= 1'b1;
            end
            if (accept[h]) begin
               wr_ptr[h] <= ptr_add(wr_ptr[h], int'(slot_n[h]));
            end
            if (pop[h]) begin
               rd_ptr[h] <= ptr_add(rd_ptr[h], 1);
            end
            count[h] <= count[h] + (accept[h] ? CNT_W'(slot_n[h]) : '0) - CNT_W'(pop[h]);
         end
      end
   end

endmodule
